// File: rtl/div_unit.sv
// Iterative 32-bit RISC-V divider (DIV/DIVU/REM/REMU).
// Restoring radix-2, one quotient bit per cycle, optional fast path for /0 and overflow.
module div_unit #(
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        rem_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic        rem_op_q;
    logic        neg_quo_q;
    logic        neg_rem_q;
    logic [31:0] result_q;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_zero;
    logic        ovf;
    logic        bypass;
    logic [31:0] byp_res;
    logic        accept;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        ge;
    logic [31:0] rem_nx;
    logic [31:0] quo_nx;
    logic [31:0] fin_res;

    always_comb begin
        a_neg    = signed_i & dividend_i[31];
        b_neg    = signed_i & divisor_i[31];
        a_mag    = a_neg ? (32'd0 - dividend_i) : dividend_i;
        b_mag    = b_neg ? (32'd0 - divisor_i) : divisor_i;
        div_zero = (divisor_i == 32'd0);
        ovf      = signed_i && (dividend_i == 32'h8000_0000)
                   && (divisor_i == 32'hFFFF_FFFF);
        bypass   = ZERO_BYPASS && (div_zero || ovf);
        if (div_zero)
            byp_res = rem_i ? dividend_i : 32'hFFFF_FFFF;
        else
            byp_res = rem_i ? 32'd0 : 32'h8000_0000;
        accept   = (state_q != CALC) && start_i && !flush_i;
    end

    // Remainder is always < divisor, so 33 bits hold both shift and borrow.
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        diff    = shifted - {1'b0, dvs_q};
        ge      = !diff[32];
        rem_nx  = ge ? diff[31:0] : shifted[31:0];
        quo_nx  = {quo_q[30:0], ge};
        if (rem_op_q)
            fin_res = neg_rem_q ? (32'd0 - rem_nx) : rem_nx;
        else
            fin_res = neg_quo_q ? (32'd0 - quo_nx) : quo_nx;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            dvs_q     <= 32'd0;
            rem_op_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= 32'd0;
        end else begin
            unique case (state_q)
                CALC: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        if (cnt_q == 5'd0) begin
                            state_q  <= DONE;
                            result_q <= fin_res;
                        end else begin
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end
                end
                IDLE, DONE: begin
                    if (accept) begin
                        rem_op_q  <= rem_i;
                        // Unsigned magnitude of /0 is all ones; keep it unsigned.
                        neg_quo_q <= (a_neg ^ b_neg) & !div_zero;
                        neg_rem_q <= a_neg;
                        rem_q     <= 32'd0;
                        quo_q     <= a_mag;
                        dvs_q     <= b_mag;
                        if (bypass) begin
                            state_q  <= DONE;
                            result_q <= byp_res;
                        end else begin
                            state_q <= CALC;
                            cnt_q   <= 5'd31;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o   = (state_q == CALC);
    assign valid_o  = (state_q == DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: default instance with the fast path,
// second instance with it disabled.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        start_a;
    logic        start_b;
    logic        rem_op;
    logic        sgn;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        busy_a;
    logic        valid_a;
    logic [31:0] result_a;
    logic        busy_b;
    logic        valid_b;
    logic [31:0] result_b;

    int checks = 0;
    int errors = 0;

    div_unit dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .start_i    (start_a),
        .rem_i      (rem_op),
        .signed_i   (sgn),
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .flush_i    (flush),
        .busy_o     (busy_a),
        .valid_o    (valid_a),
        .result_o   (result_a)
    );

    div_unit #(.ZERO_BYPASS(1'b0)) dut_nb (
        .clk_i      (clk),
        .reset_i    (reset),
        .start_i    (start_b),
        .rem_i      (rem_op),
        .signed_i   (sgn),
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .flush_i    (flush),
        .busy_o     (busy_b),
        .valid_o    (valid_b),
        .result_o   (result_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Call right after a negedge: the start is sampled at the next posedge.
    task automatic issue(input bit sel, input logic r, input logic s,
                         input logic [31:0] a, input logic [31:0] b);
        rem_op   = r;
        sgn      = s;
        dividend = a;
        divisor  = b;
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // lat = cycle index of valid (1 = first cycle after the start edge), 0 if none.
    task automatic wait_done(input bit sel, output int lat,
                             output logic [31:0] res, output int bcnt);
        lat  = 0;
        res  = 32'hDEAD_BEEF;
        bcnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (sel ? busy_b : busy_a) bcnt++;
            if (sel ? valid_b : valid_a) begin
                lat = k;
                res = sel ? result_b : result_a;
                break;
            end
        end
    endtask

    task automatic run(input string tag, input bit sel, input logic r,
                       input logic s, input logic [31:0] a,
                       input logic [31:0] b, input int exp_lat,
                       input logic [31:0] exp_res);
        int          lat;
        int          bc;
        logic [31:0] res;
        @(negedge clk);
        issue(sel, r, s, a, b);
        wait_done(sel, lat, res, bc);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy"}, bc, exp_lat - 1);
        chk({tag, "_res"}, res, exp_res);
    endtask

    initial begin
        int          lat;
        int          bc;
        logic [31:0] res;
        reset    = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        rem_op   = 1'b0;
        sgn      = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        flush    = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_result", result_a, 0);
        chk("rst_result_nb", result_b, 0);

        run("divu_100_7", 0, 0, 0, 32'd100, 32'd7, 33, 32'd14);
        run("remu_100_7", 0, 1, 0, 32'd100, 32'd7, 33, 32'd2);
        run("div_m7_2", 0, 0, 1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
        run("rem_m7_2", 0, 1, 1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
        run("divu_big_2", 0, 0, 0, 32'hFFFF_FFF9, 32'd2, 33, 32'h7FFF_FFFC);
        run("div_7_m2", 0, 0, 1, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD);

        run("div_5_0_byp", 0, 0, 1, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
        run("rem_5_0_byp", 0, 1, 1, 32'd5, 32'd0, 1, 32'd5);
        run("div_ovf_byp", 0, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1,
            32'h8000_0000);
        run("rem_ovf_byp", 0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);

        run("div_5_0_nb", 1, 0, 1, 32'd5, 32'd0, 33, 32'hFFFF_FFFF);
        run("rem_5_0_nb", 1, 1, 1, 32'd5, 32'd0, 33, 32'd5);
        run("div_m5_0_nb", 1, 0, 1, 32'hFFFF_FFFB, 32'd0, 33, 32'hFFFF_FFFF);
        run("rem_m5_0_nb", 1, 1, 1, 32'hFFFF_FFFB, 32'd0, 33, 32'hFFFF_FFFB);
        run("div_ovf_nb", 1, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 33,
            32'h8000_0000);
        run("rem_ovf_nb", 1, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0);

        // Flush in the 10th CALC cycle; previous result on dut is 0.
        @(negedge clk);
        issue(0, 0, 0, 32'd1000, 32'd3);
        for (int k = 1; k <= 10; k++) @(negedge clk);
        chk("flush_busy_before", busy_a, 1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_busy_after", busy_a, 0);
        wait_done(0, lat, res, bc);
        chk("flush_no_valid", lat, 0);
        chk("flush_result_kept", result_a, 0);
        run("div_9_3", 0, 0, 0, 32'd9, 32'd3, 33, 32'd3);

        // Flush and start together: the start is dropped.
        @(negedge clk);
        flush = 1'b1;
        issue(0, 0, 0, 32'd50, 32'd5);
        flush = 1'b0;
        @(negedge clk);
        chk("flush_start_busy", busy_a, 0);
        chk("flush_start_valid", valid_a, 0);

        // Back-to-back: new start accepted in the DONE cycle.
        run("b2b_first", 0, 0, 0, 32'd100, 32'd7, 33, 32'd14);
        issue(0, 1, 0, 32'd17, 32'd5);
        wait_done(0, lat, res, bc);
        chk("b2b_lat", lat, 33);
        chk("b2b_res", res, 32'd2);

        // Reset in the 15th CALC cycle.
        @(negedge clk);
        issue(0, 0, 0, 32'd1000, 32'd3);
        for (int k = 1; k <= 15; k++) @(negedge clk);
        chk("rst_mid_busy_before", busy_a, 1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", busy_a, 0);
        chk("rst_mid_valid", valid_a, 0);
        chk("rst_mid_result", result_a, 0);
        wait_done(0, lat, res, bc);
        chk("rst_mid_no_valid", lat, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
